spart_rx_ctrl: RTL and testbench

Receive-side sequencer for the SPART serial port. Watches the raw RxD line, finds the start bit, and drives the existing 8-bit `shifter` through its `en`/`rst` inputs. Samples each data bit at mid-bit using a 16x oversample tick from the baud generator. Validates the stop bit, latches the assembled byte for the bus interface, and reports receive-data-available, framing error and overrun.

---
 rtl/spart_rx_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_spart_rx_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/spart_rx_ctrl.sv
// rtl/spart_rx_ctrl.sv - SPART receive sequencer driving the shifter; optional parity via SPART_RX_PARITY_EN
module spart_rx_ctrl #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
`ifdef SPART_RX_PARITY_EN
    ,
    parameter bit ODD_PARITY = 1'b0
`endif
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rxd_i,
    input  logic                 baud_tick_i,
    input  logic                 rd_ack_i,
    input  logic [DATA_BITS-1:0] shifter_data_i,
    output logic                 shift_bit_o,
    output logic                 shift_en_o,
    output logic                 shift_rst_o,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rda_o,
    output logic                 framing_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
`ifdef SPART_RX_PARITY_EN
    ,
    output logic                 parity_err_o
`endif
);

    localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_q;
    logic [TW-1:0]          tick_q;
    logic [BW-1:0]          bit_q;
    logic [1:0]             sync_q;
    logic [1:0]             sync_vld_q;
    logic                   armed_q;
    logic                   shift_en_q;
    logic                   shift_rst_q;
    logic [DATA_BITS-1:0]   rx_data_q;
    logic                   rda_q;
    logic                   framing_err_q;
    logic                   overrun_q;
    logic                   rxd_s;
`ifdef SPART_RX_PARITY_EN
    logic                   par_acc_q;
    logic                   parity_err_q;
`endif

    assign rxd_s = sync_q[1];

    // sync_vld_q keeps the reset value of the synchronizer from counting as "line seen high"
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            tick_q        <= '0;
            bit_q         <= '0;
            sync_q        <= 2'b11;
            sync_vld_q    <= 2'b00;
            armed_q       <= 1'b0;
            shift_en_q    <= 1'b0;
            shift_rst_q   <= 1'b1;
            rx_data_q     <= '0;
            rda_q         <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef SPART_RX_PARITY_EN
            par_acc_q     <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            sync_q     <= {sync_q[0], rxd_i};
            sync_vld_q <= {sync_vld_q[0], 1'b1};
            shift_en_q <= 1'b0;
            if (rd_ack_i) begin
                rda_q         <= 1'b0;
                framing_err_q <= 1'b0;
                overrun_q     <= 1'b0;
`ifdef SPART_RX_PARITY_EN
                parity_err_q  <= 1'b0;
`endif
            end
            case (state_q)
                S_IDLE: begin
                    shift_rst_q <= 1'b1;
                    if (sync_vld_q[1]) begin
                        if (!armed_q) begin
                            armed_q <= rxd_s;
                        end else if (!rxd_s) begin
                            state_q <= S_START;
                            tick_q  <= '0;
                            armed_q <= 1'b0;
                        end
                    end
                end
                S_START: begin
                    if (baud_tick_i) begin
                        if (tick_q == HALF_M1) begin
                            tick_q <= '0;
                            if (!rxd_s) begin
                                state_q     <= S_DATA;
                                bit_q       <= '0;
                                shift_rst_q <= 1'b0;
`ifdef SPART_RX_PARITY_EN
                                par_acc_q   <= 1'b0;
`endif
                            end else begin
                                state_q <= S_IDLE;
                                armed_q <= 1'b1;
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (baud_tick_i) begin
                        if (tick_q == FULL_M1) begin
                            tick_q     <= '0;
                            shift_en_q <= 1'b1;
`ifdef SPART_RX_PARITY_EN
                            par_acc_q  <= par_acc_q ^ rxd_s;
`endif
                            if (bit_q == LAST_BIT) begin
                                bit_q   <= '0;
`ifdef SPART_RX_PARITY_EN
                                state_q <= S_PARITY;
`else
                                state_q <= S_STOP;
`endif
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end
`ifdef SPART_RX_PARITY_EN
                S_PARITY: begin
                    if (baud_tick_i) begin
                        if (tick_q == FULL_M1) begin
                            tick_q  <= '0;
                            state_q <= S_STOP;
                            if ((rxd_s ^ par_acc_q) != ODD_PARITY) begin
                                parity_err_q <= 1'b1;
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end
`endif
                S_STOP: begin
                    if (baud_tick_i) begin
                        if (tick_q == FULL_M1) begin
                            tick_q      <= '0;
                            state_q     <= S_IDLE;
                            shift_rst_q <= 1'b1;
                            armed_q     <= rxd_s;
                            if (rxd_s) begin
                                rx_data_q <= shifter_data_i;
                                rda_q     <= 1'b1;
                                if (rda_q && !rd_ack_i) begin
                                    overrun_q <= 1'b1;
                                end
                            end else begin
                                framing_err_q <= 1'b1;
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign shift_bit_o   = rxd_s;
    assign shift_en_o    = shift_en_q;
    assign shift_rst_o   = shift_rst_q;
    assign rx_data_o     = rx_data_q;
    assign rda_o         = rda_q;
    assign framing_err_o = framing_err_q;
    assign overrun_o     = overrun_q;
    assign busy_o        = (state_q != S_IDLE);
`ifdef SPART_RX_PARITY_EN
    assign parity_err_o  = parity_err_q;
`endif

endmodule

// File: tb/tb_spart_rx_ctrl.sv
// tb/tb_spart_rx_ctrl.sv - scoreboard bench for spart_rx_ctrl with shifter model and frame-level reference
module tb_spart_rx_ctrl;

    localparam int OS = 16;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       rxd_i = 1'b1;
    logic       baud_tick_i = 1'b0;
    logic       rd_ack_i = 1'b0;
    logic [7:0] shifter_data_i;
    logic       shift_bit_o, shift_en_o, shift_rst_o;
    logic [7:0] rx_data_o;
    logic       rda_o, framing_err_o, overrun_o, busy_o;
`ifdef SPART_RX_PARITY_EN
    logic       parity_err_o;
`endif

    spart_rx_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .rxd_i(rxd_i), .baud_tick_i(baud_tick_i),
        .rd_ack_i(rd_ack_i), .shifter_data_i(shifter_data_i),
        .shift_bit_o(shift_bit_o), .shift_en_o(shift_en_o), .shift_rst_o(shift_rst_o),
        .rx_data_o(rx_data_o), .rda_o(rda_o), .framing_err_o(framing_err_o),
        .overrun_o(overrun_o), .busy_o(busy_o)
`ifdef SPART_RX_PARITY_EN
        , .parity_err_o(parity_err_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // LSB-first shifter: each new bit enters at the top
    logic [7:0] sr = 8'h00;
    always @(posedge clk_i) begin
        if (shift_rst_o) sr <= 8'h00;
        else if (shift_en_o) sr <= {shift_bit_o, sr[7:1]};
    end
    assign shifter_data_i = sr;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        bit         rda, fe, ov, pe;
        int         shifts;
    } exp_t;
    exp_t sb_q[$];

    logic [7:0] m_data = 8'h00;
    bit m_rda = 0, m_fe = 0, m_ov = 0, m_pe = 0;
    int m_total_shifts = 0;

    function automatic exp_t snap(input int shifts);
        exp_t e;
        e.data = m_data; e.rda = m_rda; e.fe = m_fe; e.ov = m_ov; e.pe = m_pe; e.shifts = shifts;
        return e;
    endfunction

    function automatic void model_reset();
        m_data = 8'h00; m_rda = 0; m_fe = 0; m_ov = 0; m_pe = 0;
    endfunction

    function automatic void model_frame(input logic [7:0] d, input bit stop, input bit pbit, input bit ack);
`ifdef SPART_RX_PARITY_EN
        if (((^d) ^ pbit) != 1'b0) m_pe = 1;
`endif
        if (stop) begin
            if (!ack && m_rda) m_ov = 1;
            if (ack) begin m_ov = 0; m_fe = 0; m_pe = 0; end
            m_data = d;
            m_rda  = 1;
        end else begin
            if (ack) begin m_rda = 0; m_ov = 0; m_pe = 0; end
            m_fe = 1;
        end
        m_total_shifts += 8;
    endfunction

    // monitor: frame boundaries are busy rise/fall
    bit prev_busy = 0;
    int mon_ticks = 0, mon_shifts = 0, total_shifts = 0, busy_rises = 0;
    bit mon_pos_ok = 1;
    always @(negedge clk_i) begin
        exp_t e;
        if (busy_o && !prev_busy) begin
            mon_ticks = 0; mon_shifts = 0; mon_pos_ok = 1; busy_rises++;
        end
        if (shift_en_o) begin
            total_shifts++;
            if (mon_ticks != OS * 3 / 2 + OS * mon_shifts) mon_pos_ok = 0;
            mon_shifts++;
        end
        if (busy_o && baud_tick_i) mon_ticks++;
        if (!busy_o && prev_busy) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_frame_end", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("rx_data", rx_data_o, e.data);
                chk("rda", rda_o, e.rda);
                chk("framing_err", framing_err_o, e.fe);
                chk("overrun", overrun_o, e.ov);
`ifdef SPART_RX_PARITY_EN
                chk("parity_err", parity_err_o, e.pe);
`endif
                chk("shift_count", mon_shifts, e.shifts);
                chk("shift_timing", mon_pos_ok, 1);
            end
        end
        prev_busy = busy_o;
    end

    task automatic do_tick(input bit ack);
        int g = $urandom_range(4, 7);
        repeat (g - 1) begin @(posedge clk_i); #1; end
        baud_tick_i = 1'b1; rd_ack_i = ack;
        @(posedge clk_i); #1;
        baud_tick_i = 1'b0; rd_ack_i = 1'b0;
    endtask

    task automatic hold(input logic v, input int n);
        rxd_i = v;
        repeat (n) do_tick(1'b0);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop, input bit pbit, input bit ack);
        model_frame(d, stop, pbit, ack);
        sb_q.push_back(snap(8));
        hold(1'b0, OS);
        for (int i = 0; i < 8; i++) hold(d[i], OS);
`ifdef SPART_RX_PARITY_EN
        hold(pbit, OS);
`endif
        rxd_i = stop;
        repeat (OS / 2 - 1) do_tick(1'b0);
        do_tick(ack);
        repeat (OS / 2) do_tick(1'b0);
        if (!stop) hold(1'b1, OS);
    endtask

    task automatic glitch(input int len);
        sb_q.push_back(snap(0));
        hold(1'b0, len);
        hold(1'b1, OS);
    endtask

    task automatic ack_pulse();
        @(posedge clk_i); #1; rd_ack_i = 1'b1;
        @(posedge clk_i); #1; rd_ack_i = 1'b0;
        m_rda = 0; m_fe = 0; m_ov = 0; m_pe = 0;
        chk("ack_rda", rda_o, 0);
        chk("ack_fe", framing_err_o, 0);
        chk("ack_ov", overrun_o, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises0;
        logic [7:0] d;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        chk("rst_shift_en", shift_en_o, 0);
        chk("rst_shift_rst", shift_rst_o, 1);
        chk("rst_rx_data", rx_data_o, 0);
        chk("rst_rda", rda_o, 0);
        chk("rst_fe", framing_err_o, 0);
        chk("rst_ov", overrun_o, 0);
        chk("rst_busy", busy_o, 0);

        hold(1'b1, 200);
        chk("idle_shifts", total_shifts, 0);
        chk("idle_busy_rises", busy_rises, 0);
        chk("idle_shift_rst", shift_rst_o, 1);

        send_frame(8'h5A, 1, ^8'h5A, 0);
        ack_pulse();
        glitch(4);
        send_frame(8'hA5, 0, ^8'hA5, 0);
        send_frame(8'h3C, 1, ^8'h3C, 0);
        ack_pulse();
        send_frame(8'h11, 1, ^8'h11, 0);
        send_frame(8'h22, 1, ^8'h22, 0);
        ack_pulse();
        send_frame(8'h11, 1, ^8'h11, 0);
        send_frame(8'h22, 1, ^8'h22, 1);
        ack_pulse();

        // abort after the third data strobe with the line held low
        model_reset();
        sb_q.push_back(snap(3));
        m_total_shifts += 3;
        hold(1'b0, OS * 3 + OS * 3 / 4);
        @(posedge clk_i); #1 rst_i = 1'b1;
        @(posedge clk_i); #1 rst_i = 1'b0;
        rises0 = busy_rises;
        hold(1'b0, 40);
        chk("stuck_low_no_start", busy_rises, rises0);
        hold(1'b1, OS);
        send_frame(8'hFF, 1, ^8'hFF, 0);
        ack_pulse();
`ifdef SPART_RX_PARITY_EN
        send_frame(8'h07, 1, 1'b0, 0);
        ack_pulse();
`endif

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                glitch($urandom_range(1, 6));
            end else begin
                d = 8'($urandom);
                send_frame(d, $urandom_range(0, 7) != 0, 1'($urandom), $urandom_range(0, 4) == 0);
            end
            if ($urandom_range(0, 2) == 0) ack_pulse();
            else hold(1'b1, $urandom_range(0, 3));
        end

        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk_i);
        chk("scoreboard_drained", sb_q.size(), 0);
        chk("total_shifts", total_shifts, m_total_shifts);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
